// File: rtl/fwpayload_sram_arb_if.sv
// fwpayload_sram_arb_if: flattened initiator Wishbone buses plus the SRAM macro port and status
interface fwpayload_sram_arb_if #(parameter int N_INIT = 4);
    logic [32*N_INIT-1:0] i_adr, i_dat_w, i_dat_r;
    logic [4*N_INIT-1:0]  i_sel;
    logic [N_INIT-1:0]    i_we, i_cyc, i_stb, i_ack, i_err;
    logic                 sram_en, sram_we, busy;
    logic [7:0]           sram_adr;
    logic [3:0]           sram_sel;
    logic [31:0]          sram_dat_w, sram_dat_r;
    logic [1:0]           grant_id;
    modport slave (
        input  i_adr, i_dat_w, i_sel, i_we, i_cyc, i_stb, sram_dat_r,
        output i_ack, i_err, i_dat_r, sram_en, sram_we, sram_adr, sram_sel, sram_dat_w, busy, grant_id
    );
    modport master (
        output i_adr, i_dat_w, i_sel, i_we, i_cyc, i_stb, sram_dat_r,
        input  i_ack, i_err, i_dat_r, sram_en, sram_we, sram_adr, sram_sel, sram_dat_w, busy, grant_id
    );
endinterface

// File: rtl/fwpayload_sram_arb.sv
// fwpayload_sram_arb: round-robin Wishbone arbiter/sequencer for the shared 32x256 payload SRAM
module fwpayload_sram_arb #(
    parameter int N_INIT      = 4,
    parameter int WAIT_STATES = 1
) (
    input logic                 clock,
    input logic                 reset_n,
    fwpayload_sram_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t            state, state_nxt;
    logic [1:0]        last_grant, grant_id, win, idx;
    logic [N_INIT-1:0] req, gsel;
    logic [31:0]       adr_q, dat_q, rdata;
    logic [3:0]        sel_q;
    logic [2:0]        cnt;
    logic              we_q, abort, cap, oow, done, unused_adr;

    assign req        = bus.i_cyc & bus.i_stb;
    assign oow        = adr_q[15:10] != 6'd0;
    assign done       = state == RESP && !abort;
    assign unused_adr = ^{adr_q[31:16], adr_q[1:0]};

    // nearest requester after last_grant wins, so the lowest k is assigned last
    always_comb begin
        win = last_grant;
        idx = 2'd0;
        for (int k = N_INIT; k >= 1; k--) begin
            idx = 2'((int'(last_grant) + k) % N_INIT);
            if (req[idx]) win = idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |req ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT_STATES > 0 ? WAIT : RESP;
            WAIT:    state_nxt = cnt == 3'd0 ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 2'(N_INIT - 1);
            grant_id   <= 2'd0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            abort      <= 1'b0;
            cap        <= 1'b0;
            cnt        <= '0;
            rdata      <= '0;
        end else begin
            state <= state_nxt;
            cap   <= bus.sram_en;
            if (cap) rdata <= bus.sram_dat_r;
            if (state == IDLE && |req) begin
                grant_id   <= win;
                last_grant <= win;
                adr_q      <= bus.i_adr[32*win +: 32];
                dat_q      <= bus.i_dat_w[32*win +: 32];
                sel_q      <= bus.i_sel[4*win +: 4];
                we_q       <= bus.i_we[win];
                abort      <= 1'b0;
            end
            if ((state == ISSUE || state == WAIT) && !bus.i_cyc[grant_id]) abort <= 1'b1;
            if (state == ISSUE) cnt <= 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
            else if (state == WAIT) cnt <= cnt - 3'd1;
        end
    end

    always_comb begin
        gsel           = '0;
        gsel[grant_id] = 1'b1;
    end

    assign bus.busy       = state != IDLE;
    assign bus.grant_id   = grant_id;
    assign bus.sram_en    = state == ISSUE && !oow;
    assign bus.sram_we    = we_q;
    assign bus.sram_adr   = adr_q[9:2];
    assign bus.sram_sel   = sel_q;
    assign bus.sram_dat_w = dat_q;
    assign bus.i_ack      = done && !oow ? gsel : '0;
    assign bus.i_err      = done && oow ? gsel : '0;

    // with no wait states the macro output is still live during RESP, so it bypasses rdata
    always_comb begin
        bus.i_dat_r = '0;
        if (done && !oow && !we_q) bus.i_dat_r[32*grant_id +: 32] = WAIT_STATES == 0 ? bus.sram_dat_r : rdata;
    end
endmodule

// File: doc/fwpayload_sram_arb.md
# fwpayload_sram_arb

Round-robin Wishbone arbiter and sequencer that shares the payload's single-port 32x256 program/data SRAM between up to four initiators: core instruction, core data, management and LA. It replaces the fixed four-state SRAM bridge with these features:
- fair, locked grants;
- a parameterised access latency;
- registered read data;
- an error response for addresses outside the SRAM window.

It sits between the interconnect's SRAM target slot(s) and the SRAM macro.

## Interface
Parameters:
- N_INIT, 4: number of initiator ports (2..4).
- WAIT_STATES, 1: extra SRAM cycles between issue and read-data capture (0..7).

Ports (per-initiator buses flattened, initiator i at bit slice i):
- clock  in  1  sole clock.
- reset_n  in  1  reset; asynchronous, active-low.
- i_adr  in  32*N_INIT  byte address; only bits [15:0] are used.
- i_dat_w  in  32*N_INIT  write data.
- i_sel  in  4*N_INIT  byte lane enables.
- i_we  in  N_INIT  write enable.
- i_cyc  in  N_INIT  bus cycle.
- i_stb  in  N_INIT  strobe.
- i_ack  out  N_INIT  one-cycle acknowledge.
- i_err  out  N_INIT  one-cycle error (replaces ack).
- i_dat_r  out  32*N_INIT  read data; valid only with ack; 0 on non-granted ports.
- sram_en  out  1  SRAM access strobe (one cycle per access).
- sram_we  out  1  write enable, qualified by sram_en.
- sram_adr  out  8  word address (i_adr[9:2] of the winner).
- sram_sel  out  4  byte lanes.
- sram_dat_w  out  32  write data.
- sram_dat_r  in  32  SRAM read data, valid one cycle after sram_en.
- busy  out  1  state != IDLE.
- grant_id  out  2  currently/last granted initiator.

## Operation
- A request from initiator i is i_cyc[i] & i_stb[i].

States:
- **IDLE**
  - If any request is present: choose a winner round-robin, searching from last_grant+1 modulo N_INIT.
  - Register the winner's adr/dat_w/sel/we, set grant_id and last_grant to the winner, then go to ISSUE.
- **ISSUE**, one cycle.
  - If the latched adr[15:10] != 0 (out of window): sram_en = 0, go to RESP with err.
  - Otherwise: sram_en = 1, with sram_we/adr/sel/dat_w taken from the latched request.
  - Then go to WAIT if WAIT_STATES > 0, else to RESP.
- **WAIT**
  - Down-counter loaded with WAIT_STATES-1 on entry.
  - Go to RESP when the counter reaches 0.
  - sram_dat_r is captured into the rdata register on the cycle following sram_en. With WAIT_STATES=0 it is captured on entry to RESP.
- **RESP**, one cycle.
  - Assert i_ack[grant] (or i_err[grant]).
  - i_dat_r[grant] = rdata for reads; 0 for writes and errors.
  - Go to IDLE.

Grant lock and abort:
- The grant is locked from IDLE exit until RESP ends; other requests wait.
- If the granted initiator's i_cyc falls in WAIT or ISSUE: finish the SRAM access already issued (a write issued in ISSUE is committed), suppress ack/err, and return to IDLE at the normal RESP slot.

Other rules:
- The winner's request is re-sampled only in IDLE. An initiator that holds stb through its ack gets a new access only after re-arbitration.
- sram_sel is passed through unchanged. The SRAM performs the byte masking.

Reset values:
- state = IDLE, last_grant = N_INIT-1 (initiator 0 wins first), grant_id = 0.
- All ack/err = 0, sram_en = 0, sram_we = 0, rdata = 0.
- sram_adr/sel/dat_w = 0, busy = 0.

## Timing
- Request sampled at edge 0. Access latency:
  - ISSUE during cycle 1;
  - WAIT during cycles 2..1+WAIT_STATES;
  - ack during cycle 2+WAIT_STATES.
- With the default WAIT_STATES=1, ack is in cycle 3, the same as the old bridge.
- Back-to-back throughput is one access per 3+WAIT_STATES cycles. IDLE always lasts at least one cycle between accesses.
- All outputs are registered or decoded from registered state only. There is no combinational path from i_* to i_ack/i_err.
- Asserting reset_n low asynchronously forces all outputs to their reset values within the same cycle, including mid-WAIT and mid-RESP.
- The first arbitration after deassertion happens on the first clock edge with reset_n high.

## Test plan
- **Single read:** preload word 0x10 = 0xDEADBEEF; initiator 2 reads adr 0x40 with WAIT_STATES=1 -> sram_en in cycle 1, sram_adr = 0x10, i_ack[2] and i_dat_r[2] = 0xDEADBEEF in cycle 3, all other ack = 0.
- **Contention:** initiators 0 and 2 request at the same edge from reset -> 0 granted first, ack in cycle 3; 2 granted at the next IDLE, ack in cycle 7; grant_id follows 0 then 2.
- **Fairness:** all four hold requests continuously for 16 accesses -> grant order 0,1,2,3 repeating, exactly 4 acks each, no port starved.
- **Abort:** initiator 1 writes 0x12345678 with sel=4'b0011, then drops i_cyc in WAIT -> no ack; a subsequent read of the same word returns the low halfword 0x5678 merged with the old upper halfword.
- **Error:** a read at adr 0x0000_0400 -> sram_en never asserted, i_err asserted in cycle 3, i_dat_r = 0.
- **Reset mid-access, and WAIT_STATES=0:** pull reset_n low in WAIT -> busy/ack/sram_en are 0 immediately, and after release initiator 0 wins first. With WAIT_STATES=0, a read is acked in cycle 2 with correct data.
